// File: rtl/dbg_bus_arb_pkg.sv
// Shared debug-bus arbiter package.
// Holds the arbiter state encoding, the captured request record and a small
// round-robin pointer helper. The request record is sized for the widest debug
// bus in use (DbgBusAw/DbgBusDw). Arbiter instances with narrower AW/DW
// zero-extend into it and slice back out.
package dbg_bus_arb_pkg;

  localparam int unsigned DbgBusAw = 32;
  localparam int unsigned DbgBusDw = 32;
  localparam int unsigned DbgBusBw = DbgBusDw / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } dbg_bus_arb_state_e;

  typedef struct packed {
    logic [DbgBusAw-1:0] addr;
    logic                we;
    logic [DbgBusDw-1:0] wdata;
    logic [DbgBusBw-1:0] be;
    logic [1:0]          size;
  } dbg_bus_req_t;

  // Index of the requester after idx, wrapping from n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dbg_bus_arb_if.sv
// Debug-bus arbiter interface.
// Bundles the requester-side req/gnt/rvalid bus and the downstream host-adapter
// bus. Signal suffixes describe the direction as seen by the arbiter.
//   slave  : arbiter view (requests in, grants/responses out, downstream out)
//   master : environment view (requesters plus host adapter)
interface dbg_bus_arb_if #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
);
  // requester side
  logic [NumReq-1:0]          req_i;
  logic [NumReq-1:0]          gnt_o;
  logic [NumReq*AW-1:0]       addr_i;
  logic [NumReq-1:0]          we_i;
  logic [NumReq*DW-1:0]       wdata_i;
  logic [NumReq*(DW/8)-1:0]   be_i;
  logic [NumReq*2-1:0]        size_i;
  logic [NumReq-1:0]          rvalid_o;
  logic [DW-1:0]              rdata_o;
  logic                       err_o;
  // downstream host-adapter side
  logic                       down_req_o;
  logic                       down_gnt_i;
  logic [AW-1:0]              down_addr_o;
  logic                       down_we_o;
  logic [DW-1:0]              down_wdata_o;
  logic [DW/8-1:0]            down_be_o;
  logic [1:0]                 down_size_o;
  logic                       down_rvalid_i;
  logic [DW-1:0]              down_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, be_i, size_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output down_req_o, down_addr_o, down_we_o, down_wdata_o, down_be_o, down_size_o,
    input  down_gnt_i, down_rvalid_i, down_rdata_i
  );

  modport master (
    output req_i, addr_i, we_i, wdata_i, be_i, size_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  down_req_o, down_addr_o, down_we_o, down_wdata_o, down_be_o, down_size_o,
    output down_gnt_i, down_rvalid_i, down_rdata_i
  );

endinterface

// File: rtl/dbg_bus_arb_rr_pick.sv
// dbg_rr_pick: combinational round-robin priority picker.
// Returns the first asserted request at or after ptr, searching upward modulo
// NumReq, as a one-hot vector plus its index.
//   req        in   NumReq  request vector
//   ptr        in   IdxW    search start position (must be < NumReq)
//   winner_oh  out  NumReq  one-hot winner (all zero when no request)
//   winner_idx out  IdxW    winner index (0 when no request)
//   winner_vld out  1       any request present
module dbg_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] winner_oh,
  output logic [IdxW-1:0]   winner_idx,
  output logic              winner_vld
);

  logic [NumReq-1:0] oh_s;
  logic [IdxW-1:0]   idx_s;
  logic              vld_s;
  logic [IdxW-1:0]   pos_s;

  // Rotating priority search: the first hit starting from ptr wins.
  always_comb begin
    oh_s  = '0;
    idx_s = '0;
    vld_s = 1'b0;
    pos_s = '0;
    for (int i = 0; i < NumReq; i++) begin
      pos_s = IdxW'((32'(ptr) + 32'(i)) % NumReq);
      if (!vld_s && req[pos_s]) begin
        vld_s       = 1'b1;
        idx_s       = pos_s;
        oh_s[pos_s] = 1'b1;
      end else begin
        vld_s = vld_s;
      end
    end
  end

  assign winner_oh  = oh_s;
  assign winner_idx = idx_s;
  assign winner_vld = vld_s;

endmodule

// File: rtl/dbg_bus_arb.sv
// dbg_bus_arb: round-robin arbiter sharing the debug module's single
// system-bus host port between NumReq requesters.
// One transaction is in flight at a time: a request is captured in IDLE, issued
// downstream in ISSUE, and its response is routed back to the owner in WAIT_RSP.
// Ports:
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   bus     dbg_bus_arb_if.slave: requester req/gnt/rvalid bus and downstream
//           host-adapter request/response bus
// Optional feature macro: DBG_BUS_ARB_TIMEOUT_EN. When defined, a response
// watchdog forces an error response after TimeoutCycles WAIT_RSP cycles.
// When undefined, err_o is tied low and WAIT_RSP waits indefinitely.
// AW/DW must not exceed the package request-record widths.
module dbg_bus_arb
  import dbg_bus_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AW            = DbgBusAw,
  parameter int unsigned DW            = DbgBusDw,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dbg_bus_arb_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned BW   = DW / 8;

  dbg_bus_arb_state_e state_r, state_s;
  logic [IdxW-1:0]    ptr_r, ptr_s;
  logic [IdxW-1:0]    owner_r, owner_s;
  dbg_bus_req_t       cap_r, cap_s;
  dbg_bus_req_t       sel_req_s;

  logic [NumReq-1:0]  win_oh_s;
  logic [IdxW-1:0]    win_idx_s;
  logic               win_vld_s;

  logic [NumReq-1:0]  gnt_s;
  logic [NumReq-1:0]  rvalid_s;
  logic [DW-1:0]      rdata_s;
  logic               err_s;
  logic               down_req_s;
  logic               timeout_s;

  dbg_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req        (bus.req_i),
    .ptr        (ptr_r),
    .winner_oh  (win_oh_s),
    .winner_idx (win_idx_s),
    .winner_vld (win_vld_s)
  );

  // Gather the winning requester's fields out of the flattened buses.
  always_comb begin
    sel_req_s = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (win_idx_s == IdxW'(k)) begin
        sel_req_s.addr  = DbgBusAw'(bus.addr_i[k*AW +: AW]);
        sel_req_s.we    = bus.we_i[k];
        sel_req_s.wdata = DbgBusDw'(bus.wdata_i[k*DW +: DW]);
        sel_req_s.be    = DbgBusBw'(bus.be_i[k*BW +: BW]);
        sel_req_s.size  = bus.size_i[k*2 +: 2];
      end else begin
        sel_req_s = sel_req_s;
      end
    end
  end

`ifdef DBG_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_r;

  // Watchdog counter: zeroed while issuing, so it starts at 0 on WAIT_RSP entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      cnt_r <= '0;
    end else if (state_r == WAIT_RSP) begin
      cnt_r <= cnt_r + CntW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = (state_r == WAIT_RSP) && (cnt_r == CntW'(TimeoutCycles - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and output decode; a real response takes priority over a timeout.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    cap_s      = cap_r;
    gnt_s      = '0;
    rvalid_s   = '0;
    rdata_s    = '0;
    err_s      = 1'b0;
    down_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_vld_s) begin
          gnt_s   = win_oh_s;
          cap_s   = sel_req_s;
          owner_s = win_idx_s;
          ptr_s   = IdxW'(rr_next(32'(win_idx_s), NumReq));
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        down_req_s = 1'b1;
        if (bus.down_gnt_i) begin
          state_s = WAIT_RSP;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_RSP: begin
        if (bus.down_rvalid_i) begin
          rvalid_s = {{(NumReq-1){1'b0}}, 1'b1} << owner_r;
          rdata_s  = bus.down_rdata_i;
          state_s  = IDLE;
        end else if (timeout_s) begin
          rvalid_s = {{(NumReq-1){1'b0}}, 1'b1} << owner_r;
          err_s    = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = WAIT_RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pointer, owner and capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      cap_r   <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      cap_r   <= cap_s;
    end
  end

  assign bus.gnt_o        = gnt_s;
  assign bus.rvalid_o     = rvalid_s;
  assign bus.rdata_o      = rdata_s;
  assign bus.err_o        = err_s;
  assign bus.down_req_o   = down_req_s;
  assign bus.down_addr_o  = cap_r.addr[AW-1:0];
  assign bus.down_we_o    = cap_r.we;
  assign bus.down_wdata_o = cap_r.wdata[DW-1:0];
  assign bus.down_be_o    = cap_r.be[BW-1:0];
  assign bus.down_size_o  = cap_r.size;

endmodule

// File: tb/tb_dbg_bus_arb.sv
// Self-checking bench for dbg_bus_arb (NumReq=2, AW=DW=32, TimeoutCycles=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A per-cycle vector table covers single read, stray responses
// and alternating fairness; directed sequences cover stall, reset mid-operation
// and the response watchdog.
module tb_dbg_bus_arb;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  dbg_bus_arb_if #(.NumReq(2), .AW(32), .DW(32)) bus ();

  dbg_bus_arb #(
    .NumReq        (2),
    .AW            (32),
    .DW            (32),
    .TimeoutCycles (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        dgnt;
    logic        drv;
    logic [31:0] drdata;
    logic [1:0]  e_gnt;
    logic        e_dreq;
    logic [31:0] e_addr;
    logic        e_we;
    logic [1:0]  e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic dgnt, input logic drv,
                       input logic [31:0] drdata);
    bus.req_i         = req;
    bus.down_gnt_i    = dgnt;
    bus.down_rvalid_i = drv;
    bus.down_rdata_i  = drdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},    64'(bus.gnt_o), 64'd0);
    chk({tag, " rvalid"}, 64'(bus.rvalid_o), 64'd0);
    chk({tag, " rdata"},  64'(bus.rdata_o), 64'd0);
    chk({tag, " err"},    64'(bus.err_o), 64'd0);
    chk({tag, " dreq"},   64'(bus.down_req_o), 64'd0);
    chk({tag, " daddr"},  64'(bus.down_addr_o), 64'd0);
    chk({tag, " dwe"},    64'(bus.down_we_o), 64'd0);
    chk({tag, " dwdata"}, 64'(bus.down_wdata_o), 64'd0);
    chk({tag, " dbe"},    64'(bus.down_be_o), 64'd0);
    chk({tag, " dsize"},  64'(bus.down_size_o), 64'd0);
  endtask

  initial begin
    int rv_cycles;
    passed = 0;
    total  = 0;

    //            req    g     v     rdata          gnt    dreq  addr  we    rv     rdata
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0};
    vecs[1]  = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A0,    1'b0, 2'b00, 32'h0};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, A0,    1'b0, 2'b00, 32'h0};
    vecs[3]  = '{2'b00, 1'b0, 1'b1, 32'hCAFE_F00D, 2'b00, 1'b0, A0,    1'b0, 2'b01, 32'hCAFE_F00D};
    vecs[4]  = '{2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, A0,    1'b0, 2'b00, 32'h0};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b10, 1'b0, A0,    1'b0, 2'b00, 32'h0};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 32'hBEEF_0000, 2'b00, 1'b1, A1,    1'b1, 2'b00, 32'h0};
    vecs[7]  = '{2'b11, 1'b0, 1'b1, 32'h0000_0A01, 2'b00, 1'b0, A1,    1'b1, 2'b10, 32'h0000_0A01};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, A1,    1'b1, 2'b00, 32'h0};
    vecs[9]  = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A0,    1'b0, 2'b00, 32'h0};
    vecs[10] = '{2'b11, 1'b0, 1'b1, 32'h0000_0B02, 2'b00, 1'b0, A0,    1'b0, 2'b01, 32'h0000_0B02};
    vecs[11] = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b10, 1'b0, A0,    1'b0, 2'b00, 32'h0};
    vecs[12] = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A1,    1'b1, 2'b00, 32'h0};
    vecs[13] = '{2'b11, 1'b0, 1'b1, 32'h0000_0C03, 2'b00, 1'b0, A1,    1'b1, 2'b10, 32'h0000_0C03};
    vecs[14] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, A1,    1'b1, 2'b00, 32'h0};

    // Static requester fields.
    bus.addr_i  = {A1, A0};
    bus.we_i    = 2'b10;
    bus.wdata_i = {W1, W0};
    bus.be_i    = {4'h3, 4'hF};
    bus.size_i  = {2'd1, 2'd2};
    drive(2'b00, 1'b0, 1'b0, 32'h0);

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Per-cycle vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].dgnt, vecs[i].drv, vecs[i].drdata);
      @(negedge clk);
      chk($sformatf("v%0d gnt", i),    64'(bus.gnt_o),       64'(vecs[i].e_gnt));
      chk($sformatf("v%0d dreq", i),   64'(bus.down_req_o),  64'(vecs[i].e_dreq));
      chk($sformatf("v%0d daddr", i),  64'(bus.down_addr_o), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d dwe", i),    64'(bus.down_we_o),   64'(vecs[i].e_we));
      chk($sformatf("v%0d rvalid", i), 64'(bus.rvalid_o),    64'(vecs[i].e_rv));
      chk($sformatf("v%0d rdata", i),  64'(bus.rdata_o),     64'(vecs[i].e_rdata));
      chk($sformatf("v%0d err", i),    64'(bus.err_o),       64'd0);
      next_cycle();
    end

    // Stall: downstream grant withheld for 5 cycles, req_i[1] arrives mid-issue.
    drive(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("stall gnt", 64'(bus.gnt_o), 64'(2'b01));
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      drive((c >= 2) ? 2'b10 : 2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("stall%0d dreq", c),   64'(bus.down_req_o),   64'd1);
      chk($sformatf("stall%0d daddr", c),  64'(bus.down_addr_o),  64'(A0));
      chk($sformatf("stall%0d dwdata", c), 64'(bus.down_wdata_o), 64'(W0));
      chk($sformatf("stall%0d gnt", c),    64'(bus.gnt_o),        64'd0);
      next_cycle();
    end
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("stall dbe",   64'(bus.down_be_o),   64'(4'hF));
    chk("stall dsize", 64'(bus.down_size_o), 64'(2'd2));
    chk("stall dwe",   64'(bus.down_we_o),   64'd0);
    chk("stall dreq6", 64'(bus.down_req_o),  64'd1);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    chk("stall rvalid", 64'(bus.rvalid_o), 64'(2'b01));
    chk("stall rdata",  64'(bus.rdata_o),  64'(32'h5555_AAAA));
    next_cycle();

    // Reset during WAIT_RSP with ptr=1, then a late response must be dropped.
    drive(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst pre gnt", 64'(bus.gnt_o), 64'(2'b01));
    next_cycle();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    next_cycle();
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0099);
    @(negedge clk);
    chk_all_zero("midrst");
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("late rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("late rdata",  64'(bus.rdata_o),  64'd0);
    next_cycle();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("post rst ptr gnt", 64'(bus.gnt_o), 64'(2'b01));
    next_cycle();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("post rst daddr", 64'(bus.down_addr_o), 64'(A0));
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0D04);
    @(negedge clk);
    chk("post rst rvalid", 64'(bus.rvalid_o), 64'(2'b01));
    next_cycle();

`ifdef DBG_BUS_ARB_TIMEOUT_EN
    // Watchdog: forced error on the 8th WAIT_RSP cycle, then real response wins.
    for (int t = 0; t < 2; t++) begin
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("to%0d gnt", t), 64'(bus.gnt_o), 64'(2'b01));
      next_cycle();
      drive(2'b00, 1'b1, 1'b0, 32'h0);
      next_cycle();
      for (int w = 1; w <= 8; w++) begin
        if (w == 8 && t == 1) begin
          drive(2'b00, 1'b0, 1'b1, 32'h0000_0077);
        end else begin
          drive(2'b00, 1'b0, 1'b0, 32'h1234_5678);
        end
        @(negedge clk);
        if (w < 8) begin
          chk($sformatf("to%0d w%0d rvalid", t, w), 64'(bus.rvalid_o), 64'd0);
        end else begin
          chk($sformatf("to%0d rvalid", t), 64'(bus.rvalid_o), 64'(2'b01));
          chk($sformatf("to%0d err", t),    64'(bus.err_o),    (t == 0) ? 64'd1 : 64'd0);
          chk($sformatf("to%0d rdata", t),  64'(bus.rdata_o),  (t == 0) ? 64'd0 : 64'h77);
        end
        next_cycle();
      end
    end
`else
    // No watchdog: WAIT_RSP must still be pending after 100 silent cycles.
    drive(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("nto gnt", 64'(bus.gnt_o), 64'(2'b01));
    next_cycle();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    next_cycle();
    rv_cycles = 0;
    for (int w = 0; w < 100; w++) begin
      drive(2'b00, 1'b0, 1'b0, 32'h1234_5678);
      @(negedge clk);
      if (bus.rvalid_o != 2'b00 || bus.err_o != 1'b0) begin
        rv_cycles++;
      end else begin
        rv_cycles = rv_cycles;
      end
      next_cycle();
    end
    chk("nto silent cycles", 64'(rv_cycles), 64'd0);
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0E05);
    @(negedge clk);
    chk("nto rvalid", 64'(bus.rvalid_o), 64'(2'b01));
    chk("nto rdata",  64'(bus.rdata_o),  64'(32'h0000_0E05));
    chk("nto err",    64'(bus.err_o),    64'd0);
    next_cycle();
`endif

    drive(2'b00, 1'b0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
